// File: rtl/icmp_pkg.sv
// icmp_pkg: shared defaults, FSM encodings and length check for the ICMP echo buffer.
// rev 1.0
`default_nettype none

package icmp_pkg;

  localparam int DEPTH_DEF      = 2048;
  localparam int GAP_CYC_DEF    = 16;
  localparam int TX_TIMEOUT_DEF = 65535;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GAP   = 2'd1;
  localparam logic [1:0] ST_START = 2'd2;
  localparam logic [1:0] ST_SEND  = 2'd3;

  // A request is echoed only if its payload is non-empty and fits the buffer.
  function automatic logic len_ok(input logic [15:0] n, input int depth);
    return (n != 16'd0) && (int'(n) <= depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/icmp_echo_ram.sv
// icmp_echo_ram: simple dual-port byte RAM with registered read.
// rev 1.0
`default_nettype none

module icmp_echo_ram #(
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [7:0]               wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [7:0]               rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/icmp_echo_buf.sv
// icmp_echo_buf: buffers an ICMP echo payload and replays it to the transmitter.
// rev 1.0
`default_nettype none

module icmp_echo_buf
  import icmp_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int GAP_CYC    = GAP_CYC_DEF,
  parameter int TX_TIMEOUT = TX_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_en,
  input  logic [7:0]  rec_data,
  input  logic        rec_pkt_done,
  input  logic [15:0] rec_byte_num,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        tx_start_en,
  output logic [7:0]  tx_data,
  output logic [15:0] tx_byte_num,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  logic [1:0]    state;
  logic [AW:0]   wr_addr;
  logic [15:0]   rd_addr;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmr;
  logic          rd_fire_q;
  logic          rd_oob_q;
  logic [7:0]    data_hold;
  logic [7:0]    ram_q;

  logic          idle;
  logic          wr_en;
  logic          pkt_ok;
  logic          rd_in;
  logic          rd_fire;
  logic          rd_oob;
  logic          timeout;
  logic [1:0]    drop_inc;
  logic [16:0]   drop_sum;

  assign idle    = (state == ST_IDLE);
  // DEPTH is a power of two, so the MSB of wr_addr flags a full buffer.
  assign wr_en   = idle && rec_en && !wr_addr[AW];
  assign pkt_ok  = len_ok(rec_byte_num, DEPTH);
  assign rd_in   = (rd_addr < tx_byte_num);
  assign rd_fire = (state == ST_SEND) && tx_req && rd_in;
  assign rd_oob  = (state == ST_SEND) && tx_req && !rd_in;
  assign timeout = (state == ST_SEND) && !tx_done && (tmr == TW'(TX_TIMEOUT - 1));

  assign drop_inc = {1'b0, rec_pkt_done && !(idle && pkt_ok)} + {1'b0, timeout};
  assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      wr_addr     <= '0;
      rd_addr     <= '0;
      gap_cnt     <= '0;
      tmr         <= '0;
      tx_byte_num <= '0;
      drop_cnt    <= '0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      case (state)
        ST_IDLE: begin
          if (wr_en) wr_addr <= wr_addr + (AW+1)'(1);
          if (rec_pkt_done) begin
            wr_addr <= '0;
            if (pkt_ok) begin
              tx_byte_num <= rec_byte_num;
              gap_cnt     <= '0;
              state       <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) state <= ST_START;
          else gap_cnt <= gap_cnt + GW'(1);
        end
        ST_START: begin
          rd_addr <= '0;
          tmr     <= '0;
          state   <= ST_SEND;
        end
        ST_SEND: begin
          if (rd_fire) rd_addr <= rd_addr + 16'd1;
          if (tx_done || timeout) state <= ST_IDLE;
          else tmr <= tmr + TW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The RAM output is not resettable, so a source select decides what tx_data shows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_fire_q <= 1'b0;
      rd_oob_q  <= 1'b0;
      data_hold <= 8'h00;
    end else begin
      rd_fire_q <= rd_fire;
      rd_oob_q  <= rd_oob;
      data_hold <= tx_data;
    end
  end

  always_comb begin
    tx_data = data_hold;
    if (rd_fire_q)     tx_data = ram_q;
    else if (rd_oob_q) tx_data = 8'h00;
  end

  assign tx_start_en = (state == ST_START);
  assign busy        = !idle;

  icmp_echo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr[AW-1:0]),
    .wdata (rec_data),
    .re    (rd_fire),
    .raddr (rd_addr[AW-1:0]),
    .rdata (ram_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_icmp_echo_buf.sv
// tb_icmp_echo_buf: directed scoreboard bench for icmp_echo_buf.
// rev 1.0
`default_nettype none

module tb_icmp_echo_buf;

  localparam int DEPTH = 128;
  localparam int GAP   = 4;
  localparam int TMO   = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rec_en = 1'b0;
  logic [7:0]  rec_data = 8'h00;
  logic        rec_pkt_done = 1'b0;
  logic [15:0] rec_byte_num = 16'd0;
  logic        tx_req = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_start_en;
  logic [7:0]  tx_data;
  logic [15:0] tx_byte_num;
  logic        busy;
  logic [15:0] drop_cnt;

  icmp_echo_buf #(
    .DEPTH      (DEPTH),
    .GAP_CYC    (GAP),
    .TX_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .rec_byte_num (rec_byte_num),
    .tx_req       (tx_req),
    .tx_done      (tx_done),
    .tx_start_en  (tx_start_en),
    .tx_data      (tx_data),
    .tx_byte_num  (tx_byte_num),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] len;
  } start_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic        req_seen = 1'b0;
  logic [7:0]  exp_data_q[$];
  start_t      exp_start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    req_seen <= tx_req & rst;
  end

  // Monitor: compares every tx_data that follows a request and every start pulse.
  always @(negedge clk) begin
    logic [7:0] ed;
    start_t     es;
    if (req_seen) begin
      if (exp_data_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL tx_data_unexpected: got 0x%0h expected no request", tx_data);
      end else begin
        ed = exp_data_q.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, ed});
      end
    end
    if (rst && tx_start_en) begin
      if (exp_start_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL start_unexpected: got tx_start_en=1 expected 0 (cycle %0d)", cyc);
      end else begin
        es = exp_start_q.pop_front();
        check("start_cycle", cyc, es.cyc);
        check("start_len", {16'd0, tx_byte_num}, {16'd0, es.len});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_start"}, {31'd0, tx_start_en}, 0);
    check({tag, "_data"},  {24'd0, tx_data}, 0);
    check({tag, "_len"},   {16'd0, tx_byte_num}, 0);
    check({tag, "_busy"},  {31'd0, busy}, 0);
    check({tag, "_drop"},  {16'd0, drop_cnt}, 0);
  endtask

  task automatic do_reset();
    rec_en = 0; rec_pkt_done = 0; rec_byte_num = 0; tx_req = 0; tx_done = 0;
    rst = 0;
    tick();
    check_zero_outputs("rst");
    rst = 1;
    tick();
  endtask

  task automatic rx_pkt(input logic [7:0] base, input int n, input logic [15:0] len,
                        input bit coincide, input bit expect_start);
    for (int i = 0; i < n; i++) begin
      rec_en   = 1;
      rec_data = base + 8'(i);
      if (coincide && i == n - 1) begin
        rec_pkt_done = 1;
        rec_byte_num = len;
        if (expect_start) exp_start_q.push_back('{cyc + GAP + 1, len});
      end
      tick();
    end
    if (!coincide || n == 0) begin
      rec_en       = 0;
      rec_pkt_done = 1;
      rec_byte_num = len;
      if (expect_start) exp_start_q.push_back('{cyc + GAP + 1, len});
      tick();
    end
    rec_en = 0; rec_pkt_done = 0; rec_byte_num = 0;
  endtask

  task automatic wait_start();
    for (int k = 0; k < 100 && !tx_start_en; k++) tick();
    if (!tx_start_en) begin
      tests++; fails++;
      $display("FAIL start_timeout: got no tx_start_en expected pulse within 100 cycles");
    end
    tick();
  endtask

  task automatic tx_read(input int n, input logic [7:0] base, input int len);
    for (int i = 0; i < n; i++) begin
      tx_req = 1;
      exp_data_q.push_back((i < len) ? base + 8'(i) : 8'h00);
      tick();
    end
    tx_req = 0;
    tick();
  endtask

  task automatic end_tx();
    tx_done = 1;
    tick();
    tx_done = 0;
    check("busy_after_done", {31'd0, busy}, 0);
  endtask

  initial begin
    tick(); tick();
    do_reset();

    // 32-byte echo, hold, out-of-range reads
    rx_pkt(8'h00, 32, 16'd32, 0, 1);
    wait_start();
    check("busy_in_send", {31'd0, busy}, 1);
    tx_read(32, 8'h00, 32);
    repeat (2) tick();
    check("tx_data_hold", {24'd0, tx_data}, 32'h1F);
    tx_read(2, 8'h00, 0);
    end_tx();

    // last byte coincident with rec_pkt_done
    rx_pkt(8'h40, 64, 16'd64, 1, 1);
    wait_start();
    tx_read(64, 8'h40, 64);
    end_tx();

    // zero and oversize lengths are dropped
    do_reset();
    rx_pkt(8'h00, 0, 16'd0, 0, 0);
    rx_pkt(8'h00, 0, 16'(DEPTH + 1), 0, 0);
    repeat (GAP + 4) tick();
    check("drop_bad_len", {16'd0, drop_cnt}, 2);
    check("busy_bad_len", {31'd0, busy}, 0);

    // second request during SEND is dropped and does not touch the reply
    do_reset();
    rx_pkt(8'hA0, 16, 16'd16, 0, 1);
    wait_start();
    tx_read(4, 8'hA0, 16);
    rx_pkt(8'hF0, 8, 16'd8, 0, 0);
    check("drop_in_send", {16'd0, drop_cnt}, 1);
    check("len_in_send", {16'd0, tx_byte_num}, 16);
    tx_read(12, 8'hA4, 12);
    end_tx();
    repeat (GAP + 4) tick();

    // SEND timeout
    do_reset();
    rx_pkt(8'h20, 8, 16'd8, 0, 1);
    wait_start();
    repeat (TMO - 1) tick();
    check("busy_before_tmo", {31'd0, busy}, 1);
    tick();
    check("busy_after_tmo", {31'd0, busy}, 0);
    check("drop_tmo", {16'd0, drop_cnt}, 1);
    rx_pkt(8'h30, 4, 16'd4, 0, 1);
    wait_start();
    tx_read(4, 8'h30, 4);
    end_tx();

    // reset mid-SEND
    rx_pkt(8'h60, 12, 16'd12, 0, 1);
    wait_start();
    tx_read(3, 8'h60, 12);
    rst = 0;
    #1;
    check_zero_outputs("midrst");
    tick();
    rst = 1;
    tick();
    rx_pkt(8'h55, 8, 16'd8, 0, 1);
    wait_start();
    tx_read(8, 8'h55, 8);
    end_tx();

    repeat (GAP + 4) tick();
    check("data_q_empty", exp_data_q.size(), 0);
    check("start_q_empty", exp_start_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/icmp_echo_buf.md
ICMP_ECHO_BUF -- requirements
Module: icmp_echo_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, meaning payload buffer size in bytes (power of two).
REQ-002 SHALL have parameter GAP_CYC, default 16, meaning idle cycles between rec_pkt_done and tx_start_en.
REQ-003 SHALL have parameter TX_TIMEOUT, default 65535, meaning maximum cycles in SEND before tx_done is seen.
REQ-004 clk  input  1  single clock for all logic; one clock, rx and tx sides both run on it.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rec_en  input  1  payload byte valid from the ICMP receiver.
REQ-007 rec_data  input  8  payload byte.
REQ-008 rec_pkt_done  input  1  one-cycle pulse at end of a valid echo request.
REQ-009 rec_byte_num  input  16  payload byte count, valid with rec_pkt_done.
REQ-010 tx_req  input  1  ICMP transmitter requests the next payload byte.
REQ-011 tx_done  input  1  one-cycle pulse when the reply frame is fully sent.
REQ-012 tx_start_en  output  1  one-cycle pulse that starts a reply.
REQ-013 tx_data  output  8  payload byte to the transmitter.
REQ-014 tx_byte_num  output  16  reply payload length, stable from tx_start_en until tx_done.
REQ-015 busy  output  1  high from the captured rec_pkt_done until return to IDLE.
REQ-016 drop_cnt  output  16  count of requests dropped, saturating at 16'hFFFF.

Function
REQ-017 FSM states SHALL be IDLE, GAP, START, SEND.
REQ-018 In IDLE, each rec_en SHALL write rec_data at wr_addr, then increment wr_addr; writes at wr_addr >= DEPTH SHALL be suppressed.
REQ-019 rec_en and rec_pkt_done in the same cycle SHALL write that byte and then complete the packet.
REQ-020 On rec_pkt_done in IDLE with 0 < rec_byte_num <= DEPTH: latch tx_byte_num, clear wr_addr, go to GAP.
REQ-021 On rec_pkt_done in IDLE with rec_byte_num == 0 or > DEPTH: increment drop_cnt, clear wr_addr, stay in IDLE.
REQ-022 rec_en while not IDLE SHALL be ignored, with no RAM write.
REQ-023 rec_pkt_done while not IDLE SHALL increment drop_cnt and SHALL NOT disturb the reply in progress.
REQ-024 GAP SHALL last exactly GAP_CYC cycles, then go to START.
REQ-025 START SHALL last one cycle with tx_start_en=1; rd_addr SHALL be cleared; next state SHALL be SEND.
REQ-026 In SEND, tx_req=1 with rd_addr < tx_byte_num SHALL read the RAM; tx_data SHALL be valid the cycle after tx_req (1-cycle latency); rd_addr SHALL increment.
REQ-027 tx_req with rd_addr >= tx_byte_num SHALL not advance rd_addr, and the following tx_data SHALL be 8'h00.
REQ-028 tx_done in SEND SHALL return the FSM to IDLE on the next cycle, with busy low.
REQ-029 If SEND lasts TX_TIMEOUT cycles without tx_done, the FSM SHALL return to IDLE and drop_cnt SHALL increment.
REQ-030 tx_data SHALL hold its last value when tx_req is low.

Reset
REQ-031 While rst=0: FSM=IDLE, tx_start_en=0, tx_data=0, tx_byte_num=0, busy=0, drop_cnt=0, and all address and timer counters 0; RAM contents are don't-care.
REQ-032 Reset asserted mid-receive or mid-send SHALL abort immediately; the first packet after release SHALL be buffered from address 0.

Structure
REQ-033 DEPTH, GAP_CYC, TX_TIMEOUT defaults and the FSM state encodings SHALL live in shared package icmp_pkg.
REQ-034 Payload storage SHALL be one sub-module icmp_echo_ram: simple dual-port, 8-bit, DEPTH entries, registered read.

Verification
REQ-035 Receive 32 bytes 0x00..0x1F, rec_byte_num=32 -> after GAP_CYC+1 cycles a single tx_start_en pulse with tx_byte_num=32; 32 tx_req give tx_data 0x00..0x1F, each one cycle late.
REQ-036 Last rec_en coincident with rec_pkt_done, 64 bytes -> byte 63 is present in the reply.
REQ-037 rec_byte_num=0, then DEPTH+1 -> no tx_start_en, drop_cnt=2.
REQ-038 Second rec_pkt_done during SEND -> drop_cnt=1, first reply data unchanged, single tx_start_en.
REQ-039 No tx_done for TX_TIMEOUT cycles -> IDLE, busy=0, drop_cnt=1; next request served normally.
REQ-040 rst pulsed low mid-SEND -> all outputs 0; next 8-byte request replies with the correct 8 bytes.
